// File: rtl/elevator_car_ctrl.sv
// ---------------------------------------------------------------------------
// ElevatorCarCtrl -- controller for a single elevator car serving floors 1..7.
//
// Call buttons are collected into a pending-request register. The car sits in
// IDLE, travels in MOVE (one floor per MOVE_CYCLES clocks) or waits with the
// door open in DOOR (DOOR_CYCLES clocks per stop). It keeps going in its
// current direction while calls remain ahead of it, then reverses or parks.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   rst_n        synchronous reset, active HIGH despite the name
//   req_i[6:0]   call buttons, bit k = floor k+1, sampled every cycle
//   elev_f_o     current floor, binary 1..7
//   dir_o        travel direction: 00 idle, 01 up, 10 down
//   door_open_o  high while stopped with the door open
//   moving_o     high while travelling between floors
//   pend_o[6:0]  pending-request register, same bit mapping as req_i
// ---------------------------------------------------------------------------
module elevator_car_ctrl #(
   parameter int MOVE_CYCLES = 50_000_000,
   parameter int DOOR_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] req_i,
   output logic [2:0] elev_f_o,
   output logic [1:0] dir_o,
   output logic       door_open_o,
   output logic       moving_o,
   output logic [6:0] pend_o
);

   localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

   localparam logic [1:0] DIR_NONE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      floor_q, floor_d;
   logic [1:0]      dir_q, dir_d;
   logic [6:0]      pend_q, pend_d;
   logic [MW-1:0]   moveCnt_q, moveCnt_d;
   logic [DW-1:0]   doorCnt_q, doorCnt_d;
   logic            doorOpen_q, doorOpen_d;
   logic            moving_q, moving_d;

   logic [6:0]      curBit;
   logic [6:0]      stepBit;
   logic [6:0]      pendIn;
   logic [2:0]      stepFloor;
   logic            anyUp;
   logic            anyDown;
   logic            stepBeyond;

   // One-hot bit of floor f in the pending vector (floor 1 is bit 0).
   function automatic logic [6:0] floorBit(input logic [2:0] f);
      return 7'b1 << (f - 3'd1);
   endfunction

   // All floors strictly above f.
   function automatic logic [6:0] aboveMask(input logic [2:0] f);
      return 7'h7F << f;
   endfunction

   // All floors strictly below f.
   function automatic logic [6:0] belowMask(input logic [2:0] f);
      return floorBit(f) - 7'd1;
   endfunction

   // Helper views of the pending register. Every decision looks at the
   // registered pending set; calls arriving this cycle only matter from the
   // next cycle on. stepFloor is the floor the car reaches when the travel
   // counter wraps, and is only meaningful while moving.
   always_comb begin
      curBit     = floorBit(floor_q);
      pendIn     = pend_q | req_i;
      anyUp      = |(pend_q & aboveMask(floor_q));
      anyDown    = |(pend_q & belowMask(floor_q));
      stepFloor  = (dir_q == DIR_DOWN) ? (floor_q - 3'd1) : (floor_q + 3'd1);
      stepBit    = floorBit(stepFloor);
      stepBeyond = (dir_q == DIR_DOWN) ? |(pend_q & belowMask(stepFloor))
                                       : |(pend_q & aboveMask(stepFloor));
   end

   // Next-state logic of the car. Whenever the car enters DOOR, the floor it
   // stops at is removed from the pending set, overriding a call for that same
   // floor in the same cycle. While the door is open, calls for the current
   // floor are masked so they neither latch nor extend the stop. A direction
   // can only be chosen when a call exists on that side, which keeps the car
   // inside 1..7 without any explicit range clamp.
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      dir_d     = dir_q;
      pend_d    = pendIn;
      moveCnt_d = moveCnt_q;
      doorCnt_d = doorCnt_q;

      case (state_q)
         IDLE: begin
            dir_d = DIR_NONE;
            if ((pend_q & curBit) != 7'd0) begin
               state_d   = DOOR;
               doorCnt_d = '0;
               pend_d    = pendIn & ~curBit;
            end else if (anyUp) begin
               state_d   = MOVE;
               dir_d     = DIR_UP;
               moveCnt_d = '0;
            end else if (anyDown) begin
               state_d   = MOVE;
               dir_d     = DIR_DOWN;
               moveCnt_d = '0;
            end
         end

         MOVE: begin
            if (moveCnt_q == MOVE_LAST) begin
               moveCnt_d = '0;
               floor_d   = stepFloor;
               if ((pend_q & stepBit) != 7'd0) begin
                  state_d   = DOOR;
                  doorCnt_d = '0;
                  pend_d    = pendIn & ~stepBit;
               end else if (!stepBeyond) begin
                  state_d = IDLE;
                  dir_d   = DIR_NONE;
               end
            end else begin
               moveCnt_d = moveCnt_q + MW'(1);
            end
         end

         DOOR: begin
            pend_d = pendIn & ~curBit;
            if (doorCnt_q == DOOR_LAST) begin
               doorCnt_d = '0;
               if ((dir_q != DIR_DOWN) && anyUp) begin
                  state_d   = MOVE;
                  dir_d     = DIR_UP;
                  moveCnt_d = '0;
               end else if ((dir_q != DIR_UP) && anyDown) begin
                  state_d   = MOVE;
                  dir_d     = DIR_DOWN;
                  moveCnt_d = '0;
               end else if (anyUp) begin
                  state_d   = MOVE;
                  dir_d     = DIR_UP;
                  moveCnt_d = '0;
               end else if (anyDown) begin
                  state_d   = MOVE;
                  dir_d     = DIR_DOWN;
                  moveCnt_d = '0;
               end else begin
                  state_d = IDLE;
                  dir_d   = DIR_NONE;
               end
            end else begin
               doorCnt_d = doorCnt_q + DW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
         end
      endcase

      doorOpen_d = (state_d == DOOR);
      moving_d   = (state_d == MOVE);
   end

   // State register. Reset abandons any trip or stop in progress and drops
   // every pending call, including calls pressed while reset is held.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= IDLE;
         floor_q    <= 3'd1;
         dir_q      <= DIR_NONE;
         pend_q     <= '0;
         moveCnt_q  <= '0;
         doorCnt_q  <= '0;
         doorOpen_q <= 1'b0;
         moving_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         moveCnt_q  <= moveCnt_d;
         doorCnt_q  <= doorCnt_d;
         doorOpen_q <= doorOpen_d;
         moving_q   <= moving_d;
      end
   end

   assign elev_f_o    = floor_q;
   assign dir_o       = dir_q;
   assign door_open_o = doorOpen_q;
   assign moving_o    = moving_q;
   assign pend_o      = pend_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_car_ctrl -- self-checking bench for elevator_car_ctrl with
// short travel and door times.
//
// A behavioural model of the car (floor number, signed direction, a set of
// called floors and countdowns) advances on every rising edge; a compare
// process checks all DUT outputs against it on every falling edge. Directed
// scenarios add hand-computed literal expectations, followed by a long run
// of random calls and occasional resets.
// ---------------------------------------------------------------------------
module tb_elevator_car_ctrl;

   localparam int MOVE_CYCLES = 4;
   localparam int DOOR_CYCLES = 3;

   localparam int PH_IDLE = 0;
   localparam int PH_MOVE = 1;
   localparam int PH_DOOR = 2;

   logic       clk;
   logic       rst_n;
   logic [6:0] req_i;
   logic [2:0] elev_f_o;
   logic [1:0] dir_o;
   logic       door_open_o;
   logic       moving_o;
   logic [6:0] pend_o;

   int numCompared   = 0;
   int numMismatched = 0;

   // Behavioural model of the car
   int  mFloor;
   int  mDir;
   int  mPhase;
   int  mTravel;
   int  mDoorLeft;
   bit  mPend[1:7];
   bit  modelValid = 1'b0;

   elevator_car_ctrl #(
      .MOVE_CYCLES(MOVE_CYCLES),
      .DOOR_CYCLES(DOOR_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .elev_f_o   (elev_f_o),
      .dir_o      (dir_o),
      .door_open_o(door_open_o),
      .moving_o   (moving_o),
      .pend_o     (pend_o)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit anyAbove(int f);
      for (int k = f + 1; k <= 7; k++) if (mPend[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit anyBelow(int f);
      for (int k = 1; k < f; k++) if (mPend[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit pendEmpty();
      for (int k = 1; k <= 7; k++) if (mPend[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [6:0] pendVector();
      logic [6:0] v;
      v = '0;
      for (int k = 1; k <= 7; k++) v[k-1] = mPend[k];
      return v;
   endfunction

   function automatic logic [1:0] dirCode();
      if (mDir > 0) return 2'b01;
      if (mDir < 0) return 2'b10;
      return 2'b00;
   endfunction

   // Advance the model by one clock using the inputs present at the edge.
   // Decisions look at the calls known before this edge; new calls join the
   // set afterwards, except for the floor where the door is (or becomes) open.
   task automatic modelStep();
      bit np[1:7];
      bit up;
      bit dn;
      if (rst_n) begin
         mFloor     = 1;
         mDir       = 0;
         mPhase     = PH_IDLE;
         mTravel    = 0;
         mDoorLeft  = 0;
         for (int k = 1; k <= 7; k++) mPend[k] = 1'b0;
         modelValid = 1'b1;
         return;
      end
      for (int k = 1; k <= 7; k++) np[k] = mPend[k] | req_i[k-1];
      case (mPhase)
         PH_IDLE: begin
            mDir = 0;
            if (mPend[mFloor]) begin
               mPhase     = PH_DOOR;
               mDoorLeft  = DOOR_CYCLES;
               np[mFloor] = 1'b0;
            end else if (anyAbove(mFloor)) begin
               mPhase  = PH_MOVE;
               mDir    = 1;
               mTravel = 0;
            end else if (anyBelow(mFloor)) begin
               mPhase  = PH_MOVE;
               mDir    = -1;
               mTravel = 0;
            end
         end
         PH_MOVE: begin
            mTravel++;
            if (mTravel == MOVE_CYCLES) begin
               mTravel = 0;
               mFloor  = mFloor + mDir;
               if (mPend[mFloor]) begin
                  mPhase     = PH_DOOR;
                  mDoorLeft  = DOOR_CYCLES;
                  np[mFloor] = 1'b0;
               end else if (!((mDir > 0) ? anyAbove(mFloor) : anyBelow(mFloor))) begin
                  mPhase = PH_IDLE;
                  mDir   = 0;
               end
            end
         end
         default: begin
            np[mFloor] = 1'b0;
            mDoorLeft--;
            if (mDoorLeft == 0) begin
               up = anyAbove(mFloor);
               dn = anyBelow(mFloor);
               mTravel = 0;
               mPhase  = PH_MOVE;
               if (mDir >= 0 && up)      mDir = 1;
               else if (mDir <= 0 && dn) mDir = -1;
               else if (up)              mDir = 1;
               else if (dn)              mDir = -1;
               else begin
                  mPhase = PH_IDLE;
                  mDir   = 0;
               end
            end
         end
      endcase
      for (int k = 1; k <= 7; k++) mPend[k] = np[k];
   endtask

   always @(posedge clk) modelStep();

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      numCompared++;
      if (act !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every falling edge, all outputs against the model
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("floor",  8'(elev_f_o),    8'(mFloor));
         checkOutput("dir",    8'(dir_o),       8'(dirCode()));
         checkOutput("door",   8'(door_open_o), 8'(mPhase == PH_DOOR));
         checkOutput("moving", 8'(moving_o),    8'(mPhase == PH_MOVE));
         checkOutput("pend",   8'(pend_o),      8'(pendVector()));
      end
   end

   // Drive one cycle of inputs, away from the rising edge
   task automatic applyStimulus(input logic [6:0] r, input logic rs);
      @(negedge clk);
      req_i = r;
      rst_n = rs;
   endtask

   initial begin
      int stops[$];
      bit reached;
      bit done;
      bit prevDoor;
      logic [6:0] rq;
      int sel;

      rst_n = 1'b1;
      req_i = '0;

      // Reset with every button pressed: none of them may latch
      repeat (3) applyStimulus(7'h7F, 1'b1);

      // Quiet after reset: parked at floor 1
      for (int i = 0; i < 10; i++) begin
         applyStimulus(7'h00, 1'b0);
         checkOutput("rstFloor", 8'(elev_f_o), 8'd1);
         checkOutput("rstDir",   8'(dir_o), 8'd0);
         checkOutput("rstDoor",  8'(door_open_o), 8'd0);
         checkOutput("rstPend",  8'(pend_o), 8'd0);
      end

      // Call at the current floor: door opens after the second edge, 3 cycles
      applyStimulus(7'b0000001, 1'b0);
      applyStimulus(7'h00, 1'b0);
      checkOutput("callLatched", 8'(pend_o), 8'h01);
      checkOutput("doorNotYet",  8'(door_open_o), 8'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(7'h00, 1'b0);
         checkOutput("doorOpen", 8'(door_open_o), 8'd1);
         checkOutput("doorPend", 8'(pend_o), 8'h00);
      end
      applyStimulus(7'h00, 1'b0);
      checkOutput("doorClosed", 8'(door_open_o), 8'd0);

      // Call floor 3 from floor 1
      applyStimulus(7'b0000100, 1'b0);
      applyStimulus(7'h00, 1'b0);
      applyStimulus(7'h00, 1'b0);
      checkOutput("depMoving", 8'(moving_o), 8'd1);
      checkOutput("depDir",    8'(dir_o), 8'h01);
      checkOutput("depFloor",  8'(elev_f_o), 8'd1);
      repeat (4) applyStimulus(7'h00, 1'b0);
      checkOutput("passFloor2", 8'(elev_f_o), 8'd2);
      checkOutput("passMoving", 8'(moving_o), 8'd1);
      repeat (4) applyStimulus(7'h00, 1'b0);
      checkOutput("arrFloor3", 8'(elev_f_o), 8'd3);
      checkOutput("arrDoor",   8'(door_open_o), 8'd1);
      checkOutput("arrDir",    8'(dir_o), 8'h01);
      repeat (3) applyStimulus(7'h00, 1'b0);
      checkOutput("parkDoor", 8'(door_open_o), 8'd0);
      checkOutput("parkDir",  8'(dir_o), 8'h00);

      // Hold the current-floor button through the whole stop
      applyStimulus(7'b0000100, 1'b0);
      applyStimulus(7'b0000100, 1'b0);
      checkOutput("holdLatched", 8'(pend_o), 8'h04);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(7'b0000100, 1'b0);
         checkOutput("holdDoor", 8'(door_open_o), 8'd1);
         checkOutput("holdPend", 8'(pend_o), 8'h00);
      end
      applyStimulus(7'h00, 1'b0);
      checkOutput("holdClosed", 8'(door_open_o), 8'd0);
      checkOutput("holdPendEnd", 8'(pend_o), 8'h00);

      // Reset while travelling between floors 4 and 5
      applyStimulus(7'b0100000, 1'b0);
      repeat (8) applyStimulus(7'h00, 1'b0);
      checkOutput("midFloor",  8'(elev_f_o), 8'd4);
      checkOutput("midMoving", 8'(moving_o), 8'd1);
      applyStimulus(7'h7F, 1'b1);
      applyStimulus(7'h00, 1'b0);
      checkOutput("abortFloor",  8'(elev_f_o), 8'd1);
      checkOutput("abortDir",    8'(dir_o), 8'h00);
      checkOutput("abortMoving", 8'(moving_o), 8'd0);
      checkOutput("abortPend",   8'(pend_o), 8'h00);

      // Head for floor 6; passing floor 3, call floors 2 and 5
      applyStimulus(7'b0100000, 1'b0);
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         applyStimulus(7'h00, 1'b0);
         if (mFloor == 3 && mPhase == PH_MOVE) reached = 1'b1;
      end
      numCompared++;
      if (!reached) begin
         numMismatched++;
         $display("[TB] FAIL reachFloor3: car never travelling at floor 3");
      end
      applyStimulus(7'b0010010, 1'b0);
      prevDoor = door_open_o;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         applyStimulus(7'h00, 1'b0);
         if (door_open_o && !prevDoor) stops.push_back(int'(elev_f_o));
         prevDoor = door_open_o;
         if (i > 2 && mPhase == PH_IDLE && pendEmpty()) done = 1'b1;
      end
      numCompared++;
      if (!done) begin
         numMismatched++;
         $display("[TB] FAIL tripTimeout: trip not finished within budget");
      end
      checkOutput("stopCount", 8'(stops.size()), 8'd3);
      checkOutput("stop1", 8'(stops.size() > 0 ? stops[0] : 0), 8'd5);
      checkOutput("stop2", 8'(stops.size() > 1 ? stops[1] : 0), 8'd6);
      checkOutput("stop3", 8'(stops.size() > 2 ? stops[2] : 0), 8'd2);
      checkOutput("tripPend", 8'(pend_o), 8'h00);
      checkOutput("tripDir",  8'(dir_o), 8'h00);

      // Random calls with occasional resets
      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 15));
         if (sel == 0)      rq = 7'(1 << $urandom_range(0, 6));
         else if (sel == 1) rq = 7'($urandom);
         else               rq = 7'h00;
         applyStimulus(rq, ($urandom_range(0, 799) == 0));
      end
      applyStimulus(7'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
